serial_cmp_sequencer: RTL and testbench

// - Compares two WIDTH-bit unsigned operands using one shared external 2-bit magnitude comparator.
// - Works MSB-first, one 2-bit slice per clock, and stops at the first unequal slice.
// - Sits between an operand producer (start handshake) and a result consumer (result handshake).
// - Drives the comparator's a/b slice inputs and reads back its g/e/l outputs.

---
 rtl/serial_cmp_sequencer.sv | 125 ++++++++++++
 tb/tb_serial_cmp_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_sequencer.sv
// MSB-first WIDTH-bit magnitude compare through one shared external 2-bit comparator,
// one slice per cycle with early exit; result held until res_ready, starts refused while busy.
module serial_cmp_sequencer #(
  parameter int WIDTH = 8  // even, >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [1:0]       cmp_a,
  output logic [1:0]       cmp_b,
  input  logic             cmp_g,
  input  logic             cmp_e,
  input  logic             cmp_l,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             g,
  output logic             e,
  output logic             l,
  output logic             err,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx;
  logic [2:0]       code;
  logic [IW-1:0]    idx_dec;

  assign code    = {cmp_g, cmp_e, cmp_l};
  assign idx_dec = idx - IW'(1);

  function automatic logic [1:0] slice_of(input logic [WIDTH-1:0] v, input logic [IW-1:0] i);
    return v[2*i +: 2];
  endfunction

  // cmp_a/cmp_b are registered one step ahead so the comparator sees the
  // current slice for the whole RUN cycle in which its answer is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      idx         <= '0;
      cmp_a       <= 2'b00;
      cmp_b       <= 2'b00;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      g           <= 1'b0;
      e           <= 1'b0;
      l           <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_reg       <= a_in;
            b_reg       <= b_in;
            idx         <= TOP_IDX;
            cmp_a       <= slice_of(a_in, TOP_IDX);
            cmp_b       <= slice_of(b_in, TOP_IDX);
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end

        RUN: begin
          if (code == 3'b010 && idx != '0) begin
            idx   <= idx_dec;
            cmp_a <= slice_of(a_reg, idx_dec);
            cmp_b <= slice_of(b_reg, idx_dec);
          end else begin
            // A non-one-hot comparator code aborts the job with err only.
            g         <= (code == 3'b100);
            e         <= (code == 3'b010);
            l         <= (code == 3'b001);
            err       <= !(code inside {3'b100, 3'b010, 3'b001});
            res_valid <= 1'b1;
            cmp_a     <= 2'b00;
            cmp_b     <= 2'b00;
            state     <= DONE;
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            g           <= 1'b0;
            e           <= 1'b0;
            l           <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          res_valid   <= 1'b0;
          cmp_a       <= 2'b00;
          cmp_b       <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_sequencer.sv
// Bench for serial_cmp_sequencer: ideal comparator model, vector table with
// scoreboard, plus backpressure, mid-run reset and comparator-fault sequences.
module tb_serial_cmp_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic [1:0] cmp_a, cmp_b;
  logic       cmp_g, cmp_e, cmp_l;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       g, e, l, err, busy;
  logic       fault = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       g;
    logic       e;
    logic       l;
    logic       err;
    int         k;
  } vec_t;

  typedef struct {
    logic g;
    logic e;
    logic l;
    logic err;
    int   k;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] run_slices[$];

  serial_cmp_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_g(cmp_g), .cmp_e(cmp_e), .cmp_l(cmp_l),
    .res_valid(res_valid), .res_ready(res_ready),
    .g(g), .e(e), .l(l), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Ideal 2-bit comparator, or a stuck-at-000 fault when requested.
  always_comb begin
    cmp_g = 1'b0;
    cmp_e = 1'b0;
    cmp_l = 1'b0;
    if (!fault) begin
      cmp_g = (cmp_a > cmp_b);
      cmp_e = (cmp_a == cmp_b);
      cmp_l = (cmp_a < cmp_b);
    end
  end

  // Slices presented during RUN cycles (busy without a result yet).
  always @(negedge clk) begin
    if (busy && !res_valid) run_slices.push_back(cmp_a);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".start_ready"}, 32'(start_ready), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, ".gelerr"}, 32'({g, e, l, err}), 32'd0);
    chk({tag, ".cmp_ab"}, 32'({cmp_a, cmp_b}), 32'd0);
  endtask

  // Handshake a job, wait for its result, compare against the scoreboard head.
  task automatic run_job(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic eg, input logic ee, input logic el, input logic eerr,
                         input int k);
    exp_t x;
    int   cyc;
    @(negedge clk);
    chk({name, ".start_ready"}, 32'(start_ready), 32'd1);
    a_in        = a;
    b_in        = b;
    start_valid = 1'b1;
    sb.push_back('{g: eg, e: ee, l: el, err: eerr, k: k});
    run_slices.delete();
    @(negedge clk);
    start_valid = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, ".latency"}, 32'(cyc), 32'(k + 1));
    if (res_valid) begin
      if (sb.size() == 0) begin
        chk({name, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        chk({name, ".result"}, 32'({g, e, l, err}), 32'({x.g, x.e, x.l, x.err}));
        chk({name, ".run_cycles"}, 32'(run_slices.size()), 32'(x.k));
      end
      chk({name, ".busy_done"}, 32'(busy), 32'd1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk_idle_outputs(name);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a: 8'hB4, b: 8'h74, g: 1, e: 0, l: 0, err: 0, k: 1};
    vecs[1] = '{a: 8'h5A, b: 8'h5A, g: 0, e: 1, l: 0, err: 0, k: 4};
    vecs[2] = '{a: 8'h12, b: 8'h13, g: 0, e: 0, l: 1, err: 0, k: 4};
    vecs[3] = '{a: 8'h00, b: 8'h00, g: 0, e: 1, l: 0, err: 0, k: 4};
    vecs[4] = '{a: 8'hFF, b: 8'h00, g: 1, e: 0, l: 0, err: 0, k: 1};
    vecs[5] = '{a: 8'h80, b: 8'hC0, g: 0, e: 0, l: 1, err: 0, k: 1};
    vecs[6] = '{a: 8'h37, b: 8'h34, g: 1, e: 0, l: 0, err: 0, k: 4};
    vecs[7] = '{a: 8'h0C, b: 8'h08, g: 1, e: 0, l: 0, err: 0, k: 3};

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    for (int i = 0; i < 8; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
              vecs[i].g, vecs[i].e, vecs[i].l, vecs[i].err, vecs[i].k);
    end

    // Slice order for an all-equal operand pair.
    run_job("seq5a", 8'h5A, 8'h5A, 0, 1, 0, 0, 4);
    chk("seq5a.n", 32'(run_slices.size()), 32'd4);
    if (run_slices.size() == 4) begin
      chk("seq5a.s0", 32'(run_slices[0]), 32'd1);
      chk("seq5a.s1", 32'(run_slices[1]), 32'd1);
      chk("seq5a.s2", 32'(run_slices[2]), 32'd2);
      chk("seq5a.s3", 32'(run_slices[3]), 32'd2);
    end

    // Backpressure: result held for 6 cycles while start pulses are ignored.
    @(negedge clk);
    a_in = 8'hB4; b_in = 8'h74; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    chk("bp.valid_at2", 32'(res_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      a_in = 8'h00; b_in = 8'hFF;
      start_valid = (i % 2 == 0);
      @(negedge clk);
      chk($sformatf("bp.hold%0d", i), 32'({res_valid, g, e, l, err, start_ready, busy}),
          32'b1100001);
    end
    start_valid = 1'b1;
    res_ready   = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    res_ready   = 1'b0;
    chk_idle_outputs("bp.release");
    @(negedge clk);
    chk_idle_outputs("bp.no_capture");

    // Reset during the second RUN cycle discards the job.
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'hFF; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    chk("rst.in_run", 32'({busy, res_valid}), 32'b10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle_outputs("rst.mid_run");
    repeat (5) begin
      @(negedge clk);
      chk("rst.no_result", 32'({res_valid, busy}), 32'd0);
    end
    run_job("rst.after", 8'h12, 8'h13, 0, 0, 1, 0, 4);

    // Comparator stuck at 000 aborts on the first slice.
    fault = 1'b1;
    run_job("fault", 8'hB4, 8'h74, 0, 0, 0, 1, 1);
    fault = 1'b0;
    run_job("fault.recover", 8'h40, 8'h80, 0, 0, 1, 0, 1);

    chk("sb.drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
